fft_xpose_seq: RTL and testbench
================================

Name: fft_xpose_seq

Overview:
- Sequencer that owns the 4x4 SRAM array of an FFT transpose stage.
  - Row 0: four long banks, 128 deep, 7-bit address.
  - Rows 1-3: twelve short banks, 32 deep, 5-bit address.
- Accepts a 4-lane complex input stream, writes it row-wise, then reads the array column-wise and presents a 4-lane complex output stream.
- Sits between the previous butterfly stage and the next.
- Generates every bank address/data/enable; unused bank inputs are held at zero.

Parameters:
- AddrLWidth, 7, long-bank address width (depth 128).
- AddrSWidth, 5, short-bank address width (depth 32).
- SfpW, `SFP_WIDTH, width of one real or imaginary sample.

Ports:
- clk_i  in  1  clock.
- rst_i  in  1  asynchronous, active-high reset.
- in_valid_i  in  1  input beat valid.
- in_ready_o  out  1  input beat accepted when valid&ready.
- in_dr_i / in_di_i  in  4*SfpW each  lane i real/imag.
- wr_en_l_o  out  4  long-bank write enable.
- addr_l_wr_o  out  4*AddrLWidth  long-bank write address.
- dr_l_o / di_l_o  out  4*SfpW each  long-bank write data.
- wr_en_s_o  out  12  short-bank write enable.
- addr_s_wr_o  out  12*AddrSWidth  short-bank write address.
- dr_s_o / di_s_o  out  12*SfpW each  short-bank write data.
- rd_en_l_o  out  4  long-bank read enable.
- addr_l_rd_o  out  4*AddrLWidth  long-bank read address.
- rd_en_s_o  out  12  short-bank read enable.
- addr_s_rd_o  out  12*AddrSWidth  short-bank read address.
- dr_l_i / di_l_i  in  4*SfpW each  long-bank read data (1-cycle latency).
- dr_s_i / di_s_i  in  12*SfpW each  short-bank read data (1-cycle latency).
- out_valid_o  out  1  output beat valid.
- out_ready_i  in  1  output accept.
- out_dr_o / out_di_o  out  4*SfpW each  output lanes.
- out_last_o  out  1  marks final beat of a frame.
- busy_o  out  1  high in READ state.

Behaviour:
- Bank map:
  - Row 0 lane i -> long[i].
  - Row r (r=1..3) lane i -> short[(r-1)*4+i].
- Reset (async, rst_i=1):
  - State WRITE; all counters 0; output buffer empty.
  - All enables, addresses and data outputs 0; out_valid_o=0, out_last_o=0, busy_o=0.
  - in_ready_o=1 after reset deasserts.
- WRITE state:
  - in_ready_o=1. Write counter wcnt counts 0..223 per accepted beat.
  - wcnt 0..127: row 0, long address wcnt[6:0].
  - wcnt 128..223: short rows. Row = 1 + (wcnt-128)/32; short address = wcnt[4:0].
  - Writes are combinational from the accepted beat: wr_en asserted only for the four banks of the active row, in the same cycle as valid&ready.
  - All other banks' enable, address and data are driven 0.
  - No write when in_valid_i=0; counters hold.
  - Accepting beat 223 moves the state to READ on the next edge; rcnt=0.
- READ state:
  - in_ready_o=0; busy_o=1.
  - Read counter rcnt counts 0..511: column c = rcnt[8:7], k = rcnt[6:0].
  - Each issue reads 4 banks:
    - lane0 from long[c] at address k;
    - lane r (r=1..3) from short[(r-1)*4+c] at address k[4:0]. Short rows are re-read for every 32-beat segment.
  - Unselected banks have rd_en=0 and read address 0.
- Latency and flow control:
  - A read issues in cycle t only if (buffer occupancy + reads in flight) < 2.
  - Read data is captured into a 2-entry output FIFO at t+1.
  - Issue-to-out_valid_o latency is 2 cycles (registered FIFO output).
  - out_ready_i low holds the output beat stable; no beat is dropped or duplicated.
  - A simultaneous capture and pop is legal at full occupancy.
- out_last_o is high with the beat of rcnt=511. When that beat is accepted, the state returns to WRITE with wcnt=0 and in_ready_o=1 on the next cycle.
- Reset mid-frame discards partial writes, in-flight reads and buffered beats. Bank contents are undefined.
- Arithmetic: counters wrap only through explicit state transitions, never by overflow.

Decomposition:
- Shared package holds:
  - AddrLWidth, AddrSWidth;
  - sfp_t, addr_t_long, addr_t_short;
  - frame constants: WrBeats=224, RdBeats=512, LongDepth=128, ShortDepth=32;
  - bank-index helper functions.
- One sub-module: fft_xpose_obuf, the 2-entry output FIFO with occupancy count, 4-lane complex payload plus last bit.

Test Plan:
- Reset check: assert rst_i mid-cycle with random inputs -> all outputs 0 immediately; in_ready_o=1 after release.
- Full frame, ramp input (lane i of beat n = 4n+i), out_ready_i=1 throughout:
  - beat 0 -> wr_en_l_o=4'hF, address 0;
  - beat 130 -> wr_en_s_o=12'h00F, address 2;
  - first output beat appears 2 cycles after READ entry, lanes = {0, 512, 640, 768};
  - 512 output beats total; last one has out_last_o=1.
- Input gaps: in_valid_i toggles every cycle -> wcnt advances only on accepted beats; READ entered after exactly 224 accepts.
- Backpressure: out_ready_i low for 10 cycles at rcnt=40 -> output held stable; at most 2 reads outstanding; sequence continues with no loss or duplicate.
- Back-to-back frames: the second frame written with data+1000 -> the second readout matches the second frame; in_ready_o returns the cycle after the last output is accepted.
- Reset at rcnt=300 -> out_valid_o drops, state WRITE; a fresh frame then reads out correctly.

Source files
------------

// File: rtl/fft_xpose_seq_pkg.sv
// fft_xpose_seq_pkg: shared widths, types, frame constants and bank-index helpers for the transpose sequencer
`ifndef SFP_WIDTH
`define SFP_WIDTH 16
`endif
package fft_xpose_seq_pkg;
  localparam int AddrLWidth = 7;
  localparam int AddrSWidth = 5;
  localparam int SfpW = `SFP_WIDTH;
  localparam int WrBeats = 224;
  localparam int RdBeats = 512;
  localparam int LongDepth = 128;
  localparam int ShortDepth = 32;
  typedef logic [SfpW-1:0] sfp_t;
  typedef logic [AddrLWidth-1:0] addr_t_long;
  typedef logic [AddrSWidth-1:0] addr_t_short;
  typedef enum logic {ST_WRITE, ST_READ} state_e;
  typedef struct packed {
    sfp_t [3:0] dr;
    sfp_t [3:0] di;
    logic last;
  } beat_t;
  function automatic int short_bank(input int row, input int lane);
    return (row - 1) * 4 + lane;
  endfunction
  function automatic int short_row(input logic [7:0] wcnt);
    return int'(wcnt[6:5]) + 1;
  endfunction
endpackage

// File: rtl/fft_xpose_obuf.sv
// fft_xpose_obuf: 2-entry registered output FIFO carrying one 4-lane complex beat plus last flag
module fft_xpose_obuf
  import fft_xpose_seq_pkg::*;
(
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       push_i,
  input  beat_t      din_i,
  input  logic       pop_i,
  output beat_t      dout_o,
  output logic       valid_o,
  output logic [1:0] cnt_o
);
  beat_t mem_q [2];
  beat_t mem_d [2];
  logic wptr_q, wptr_d, rptr_q, rptr_d, do_pop;
  logic [1:0] cnt_q, cnt_d;
  assign valid_o = cnt_q != 2'd0;
  assign dout_o = mem_q[rptr_q];
  assign cnt_o = cnt_q;
  // pointer/occupancy update; push and pop in the same cycle is fine even when full
  always_comb begin
    do_pop = pop_i && valid_o;
    cnt_d = cnt_q + 2'(push_i) - 2'(do_pop);
    wptr_d = wptr_q ^ push_i;
    rptr_d = rptr_q ^ do_pop;
    mem_d = mem_q;
    if (push_i) mem_d[wptr_q] = din_i;
  end
  // storage and pointer registers
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      mem_q[0] <= '0;
      mem_q[1] <= '0;
      wptr_q <= 1'b0;
      rptr_q <= 1'b0;
      cnt_q <= 2'd0;
    end else begin
      mem_q <= mem_d;
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
      cnt_q <= cnt_d;
    end
  end
endmodule

// File: rtl/fft_xpose_seq.sv
// fft_xpose_seq: writes a 224-beat frame row-wise into the 4x4 bank array and reads it back column-wise
module fft_xpose_seq
  import fft_xpose_seq_pkg::*;
#(
  parameter int AddrLWidth = fft_xpose_seq_pkg::AddrLWidth,
  parameter int AddrSWidth = fft_xpose_seq_pkg::AddrSWidth,
  parameter int SfpW = fft_xpose_seq_pkg::SfpW
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   in_valid_i,
  output logic                   in_ready_o,
  input  logic [4*SfpW-1:0]      in_dr_i,
  input  logic [4*SfpW-1:0]      in_di_i,
  output logic [3:0]             wr_en_l_o,
  output logic [4*AddrLWidth-1:0] addr_l_wr_o,
  output logic [4*SfpW-1:0]      dr_l_o,
  output logic [4*SfpW-1:0]      di_l_o,
  output logic [11:0]            wr_en_s_o,
  output logic [12*AddrSWidth-1:0] addr_s_wr_o,
  output logic [12*SfpW-1:0]     dr_s_o,
  output logic [12*SfpW-1:0]     di_s_o,
  output logic [3:0]             rd_en_l_o,
  output logic [4*AddrLWidth-1:0] addr_l_rd_o,
  output logic [11:0]            rd_en_s_o,
  output logic [12*AddrSWidth-1:0] addr_s_rd_o,
  input  logic [4*SfpW-1:0]      dr_l_i,
  input  logic [4*SfpW-1:0]      di_l_i,
  input  logic [12*SfpW-1:0]     dr_s_i,
  input  logic [12*SfpW-1:0]     di_s_i,
  output logic                   out_valid_o,
  input  logic                   out_ready_i,
  output logic [4*SfpW-1:0]      out_dr_o,
  output logic [4*SfpW-1:0]      out_di_o,
  output logic                   out_last_o,
  output logic                   busy_o
);
  state_e state_q, state_d;
  logic [7:0] wcnt_q, wcnt_d;
  logic [9:0] rcnt_q, rcnt_d;
  logic vld_q, vld_d, last_q, last_d;
  logic [1:0] col_q, col_d, ob_cnt;
  logic accept, issue, pop_last, ob_valid;
  beat_t push_beat, ob_beat;
  // the ready gate on rst_i keeps every write bus at zero while reset is held
  assign in_ready_o = state_q == ST_WRITE && !rst_i;
  assign accept = in_valid_i && in_ready_o;
  assign issue = state_q == ST_READ && !rcnt_q[9] && ({1'b0, ob_cnt} + {2'b0, vld_q} < 3'd2);
  assign pop_last = ob_valid && out_ready_i && ob_beat.last;
  assign busy_o = state_q == ST_READ;
  assign out_valid_o = ob_valid;
  assign out_last_o = ob_valid && ob_beat.last;
  assign out_dr_o = ob_beat.dr;
  assign out_di_o = ob_beat.di;
  // state and counter registers
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= ST_WRITE;
      wcnt_q <= '0;
      rcnt_q <= '0;
      vld_q <= 1'b0;
      last_q <= 1'b0;
      col_q <= '0;
    end else begin
      state_q <= state_d;
      wcnt_q <= wcnt_d;
      rcnt_q <= rcnt_d;
      vld_q <= vld_d;
      last_q <= last_d;
      col_q <= col_d;
    end
  end
  // next state: leave WRITE on the final accepted beat, leave READ when the last beat is taken
  always_comb begin
    state_d = state_q;
    if (state_q == ST_WRITE && accept && wcnt_q == 8'(WrBeats - 1)) state_d = ST_READ;
    if (state_q == ST_READ && pop_last) state_d = ST_WRITE;
    wcnt_d = (state_q == ST_WRITE && state_d == ST_WRITE) ? wcnt_q + 8'(accept) : '0;
    rcnt_d = (state_q == ST_READ && state_d == ST_READ) ? rcnt_q + 10'(issue) : '0;
    vld_d = issue;
    col_d = rcnt_q[8:7];
    last_d = rcnt_q == 10'(RdBeats - 1);
  end
  // bank write port: only the active row's four banks see the accepted beat
  always_comb begin
    wr_en_l_o = '0;
    addr_l_wr_o = '0;
    dr_l_o = '0;
    di_l_o = '0;
    wr_en_s_o = '0;
    addr_s_wr_o = '0;
    dr_s_o = '0;
    di_s_o = '0;
    for (int i = 0; i < 4; i++) begin
      if (accept && !wcnt_q[7]) begin
        wr_en_l_o[i] = 1'b1;
        addr_l_wr_o[i*AddrLWidth +: AddrLWidth] = AddrLWidth'(wcnt_q[6:0]);
        dr_l_o[i*SfpW +: SfpW] = in_dr_i[i*SfpW +: SfpW];
        di_l_o[i*SfpW +: SfpW] = in_di_i[i*SfpW +: SfpW];
      end
      if (accept && wcnt_q[7]) begin
        wr_en_s_o[short_bank(short_row(wcnt_q), i)] = 1'b1;
        addr_s_wr_o[short_bank(short_row(wcnt_q), i)*AddrSWidth +: AddrSWidth] = AddrSWidth'(wcnt_q[4:0]);
        dr_s_o[short_bank(short_row(wcnt_q), i)*SfpW +: SfpW] = in_dr_i[i*SfpW +: SfpW];
        di_s_o[short_bank(short_row(wcnt_q), i)*SfpW +: SfpW] = in_di_i[i*SfpW +: SfpW];
      end
    end
  end
  // bank read port: one column per issue, short rows re-read every 32-beat segment
  always_comb begin
    rd_en_l_o = '0;
    addr_l_rd_o = '0;
    rd_en_s_o = '0;
    addr_s_rd_o = '0;
    if (issue) begin
      rd_en_l_o[rcnt_q[8:7]] = 1'b1;
      addr_l_rd_o[int'(rcnt_q[8:7])*AddrLWidth +: AddrLWidth] = AddrLWidth'(rcnt_q[6:0]);
      for (int r = 1; r < 4; r++) begin
        rd_en_s_o[short_bank(r, int'(rcnt_q[8:7]))] = 1'b1;
        addr_s_rd_o[short_bank(r, int'(rcnt_q[8:7]))*AddrSWidth +: AddrSWidth] = AddrSWidth'(rcnt_q[4:0]);
      end
    end
  end
  // assemble the returning column into one output beat, captured a cycle after issue
  always_comb begin
    push_beat = '0;
    push_beat.last = last_q;
    push_beat.dr[0] = dr_l_i[int'(col_q)*SfpW +: SfpW];
    push_beat.di[0] = di_l_i[int'(col_q)*SfpW +: SfpW];
    for (int r = 1; r < 4; r++) begin
      push_beat.dr[r] = dr_s_i[short_bank(r, int'(col_q))*SfpW +: SfpW];
      push_beat.di[r] = di_s_i[short_bank(r, int'(col_q))*SfpW +: SfpW];
    end
  end
  fft_xpose_obuf u_obuf (
    .clk_i  (clk_i),
    .rst_i  (rst_i),
    .push_i (vld_q),
    .din_i  (push_beat),
    .pop_i  (out_ready_i),
    .dout_o (ob_beat),
    .valid_o(ob_valid),
    .cnt_o  (ob_cnt)
  );
endmodule

// File: tb/tb_fft_xpose_seq.sv
// tb_fft_xpose_seq: randomized frames against a frame-level transpose model with SRAM bank models
`timescale 1ns/1ps
module tb_fft_xpose_seq;
  import fft_xpose_seq_pkg::*;
  localparam int W = SfpW;
  logic clk_i = 0, rst_i = 0, in_valid_i = 0, out_ready_i = 1;
  logic in_ready_o, out_valid_o, out_last_o, busy_o;
  logic [4*W-1:0] in_dr_i = '0, in_di_i = '0, dr_l_o, di_l_o, dr_l_i, di_l_i, out_dr_o, out_di_o;
  logic [12*W-1:0] dr_s_o, di_s_o, dr_s_i, di_s_i;
  logic [3:0] wr_en_l_o, rd_en_l_o;
  logic [11:0] wr_en_s_o, rd_en_s_o;
  logic [27:0] addr_l_wr_o, addr_l_rd_o;
  logic [59:0] addr_s_wr_o, addr_s_rd_o;
  int tot = 0, bad = 0;

  fft_xpose_seq dut (
    .clk_i(clk_i), .rst_i(rst_i), .in_valid_i(in_valid_i), .in_ready_o(in_ready_o),
    .in_dr_i(in_dr_i), .in_di_i(in_di_i),
    .wr_en_l_o(wr_en_l_o), .addr_l_wr_o(addr_l_wr_o), .dr_l_o(dr_l_o), .di_l_o(di_l_o),
    .wr_en_s_o(wr_en_s_o), .addr_s_wr_o(addr_s_wr_o), .dr_s_o(dr_s_o), .di_s_o(di_s_o),
    .rd_en_l_o(rd_en_l_o), .addr_l_rd_o(addr_l_rd_o), .rd_en_s_o(rd_en_s_o), .addr_s_rd_o(addr_s_rd_o),
    .dr_l_i(dr_l_i), .di_l_i(di_l_i), .dr_s_i(dr_s_i), .di_s_i(di_s_i),
    .out_valid_o(out_valid_o), .out_ready_i(out_ready_i), .out_dr_o(out_dr_o), .out_di_o(out_di_o),
    .out_last_o(out_last_o), .busy_o(busy_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic chk(input string nm, input logic [63:0] a, input logic [63:0] e);
    tot++;
    if (a !== e) begin
      bad++;
      $display("FAIL %s got=%0h want=%0h", nm, a, e);
    end
  endtask

  // bank SRAMs with 1-cycle read latency
  logic [W-1:0] ml_r [4][128], ml_i [4][128], ms_r [12][32], ms_i [12][32];
  always @(posedge clk_i) begin
    for (int b = 0; b < 4; b++) begin
      if (wr_en_l_o[b]) begin
        ml_r[b][addr_l_wr_o[b*7 +: 7]] <= dr_l_o[b*W +: W];
        ml_i[b][addr_l_wr_o[b*7 +: 7]] <= di_l_o[b*W +: W];
      end
      if (rd_en_l_o[b]) begin
        dr_l_i[b*W +: W] <= ml_r[b][addr_l_rd_o[b*7 +: 7]];
        di_l_i[b*W +: W] <= ml_i[b][addr_l_rd_o[b*7 +: 7]];
      end
    end
    for (int b = 0; b < 12; b++) begin
      if (wr_en_s_o[b]) begin
        ms_r[b][addr_s_wr_o[b*5 +: 5]] <= dr_s_o[b*W +: W];
        ms_i[b][addr_s_wr_o[b*5 +: 5]] <= di_s_o[b*W +: W];
      end
      if (rd_en_s_o[b]) begin
        dr_s_i[b*W +: W] <= ms_r[b][addr_s_rd_o[b*5 +: 5]];
        di_s_i[b*W +: W] <= ms_i[b][addr_s_rd_o[b*5 +: 5]];
      end
    end
  end

  // frame model: beats as accepted, transposed on readout
  logic [W-1:0] mod_r [224][4], mod_i [224][4];
  logic [W-1:0] gen_r [224][4], gen_i [224][4];
  function automatic logic [W-1:0] exp_lane(input int n, input int l, input bit im);
    int c, k, src;
    c = n / 128;
    k = n % 128;
    src = (l == 0) ? k : 128 + (l - 1) * 32 + k % 32;
    return im ? mod_i[src][c] : mod_r[src][c];
  endfunction

  int acc_n = 0, out_n = 0, issued = 0, popped = 0, frames_done = 0, cyc = 0;
  int t_busy = 0, first_delay = 0, done_cnt = 0, row, c, k;
  bit busy_prev = 0, stall_prev = 0, last_pop = 0, first_seen = 0;
  logic [W-1:0] first_r [4];
  logic [3:0] snap0_wl, e_wl, e_rl;
  logic [6:0] snap0_a;
  logic [11:0] snap130_ws, e_ws, e_rs;
  logic [4:0] snap130_a;
  logic [27:0] e_al, e_arl;
  logic [59:0] e_as, e_ars;
  logic [4*W-1:0] e_dl, e_il, held_dr, held_di;
  logic [12*W-1:0] e_ds, e_is;

  // single compare process, sampling on the falling edge
  always @(negedge clk_i) begin
    cyc++;
    if (rst_i) begin
      acc_n = 0; out_n = 0; issued = 0; popped = 0;
      busy_prev = 0; stall_prev = 0; last_pop = 0;
    end else begin
      if (last_pop) begin
        chk("ready_after_last", in_ready_o, 1);
        chk("idle_after_last", busy_o, 0);
        done_cnt = out_n;
        frames_done++;
        last_pop = 0;
      end
      if (busy_o && !busy_prev) begin
        chk("accepts_before_read", acc_n, 224);
        acc_n = 0; out_n = 0; issued = 0; popped = 0;
        t_busy = cyc; first_seen = 0;
      end
      busy_prev = busy_o;
      chk("ready_vs_busy", in_ready_o, !busy_o);
      e_wl = 0; e_ws = 0; e_al = 0; e_as = 0; e_dl = 0; e_il = 0; e_ds = 0; e_is = 0;
      if (in_valid_i && in_ready_o && acc_n < 224) begin
        if (acc_n < 128) begin
          e_wl = 4'hF;
          e_al = {4{7'(acc_n)}};
          e_dl = in_dr_i;
          e_il = in_di_i;
        end else begin
          row = (acc_n - 128) / 32;
          e_ws = 12'hF << (4 * row);
          for (int i = 0; i < 4; i++) begin
            e_as[(4*row+i)*5 +: 5] = 5'(acc_n % 32);
            e_ds[(4*row+i)*W +: W] = in_dr_i[i*W +: W];
            e_is[(4*row+i)*W +: W] = in_di_i[i*W +: W];
          end
        end
        for (int i = 0; i < 4; i++) begin
          mod_r[acc_n][i] = in_dr_i[i*W +: W];
          mod_i[acc_n][i] = in_di_i[i*W +: W];
        end
        if (acc_n == 0) begin snap0_wl = wr_en_l_o; snap0_a = addr_l_wr_o[6:0]; end
        if (acc_n == 130) begin snap130_ws = wr_en_s_o; snap130_a = addr_s_wr_o[4:0]; end
        acc_n++;
      end
      chk("wr_en_l", wr_en_l_o, e_wl);
      chk("wr_en_s", wr_en_s_o, e_ws);
      chk("addr_l_wr", addr_l_wr_o, e_al);
      chk("addr_s_wr", addr_s_wr_o, e_as);
      chk("data_l_wr", {dr_l_o, di_l_o} == {e_dl, e_il}, 1);
      chk("data_s_wr", {dr_s_o, di_s_o} == {e_ds, e_is}, 1);
      e_rl = 0; e_rs = 0; e_arl = 0; e_ars = 0;
      if (rd_en_l_o != 0 || rd_en_s_o != 0) begin
        c = (issued / 128) % 4;
        k = issued % 128;
        e_rl = 4'b1 << c;
        e_rs = 12'h111 << c;
        e_arl[c*7 +: 7] = 7'(k);
        for (int r = 0; r < 3; r++) e_ars[(4*r+c)*5 +: 5] = 5'(k % 32);
        issued++;
      end
      chk("rd_en_l", rd_en_l_o, e_rl);
      chk("rd_en_s", rd_en_s_o, e_rs);
      chk("addr_l_rd", addr_l_rd_o, e_arl);
      chk("addr_s_rd", addr_s_rd_o, e_ars);
      if (stall_prev) begin
        chk("hold_valid", out_valid_o, 1);
        chk("hold_data", {out_dr_o, out_di_o} == {held_dr, held_di}, 1);
      end
      if (out_valid_o) begin
        if (!first_seen) begin
          first_seen = 1;
          first_delay = cyc - t_busy;
          for (int l = 0; l < 4; l++) first_r[l] = out_dr_o[l*W +: W];
        end
        if (out_n < 512) begin
          for (int l = 0; l < 4; l++) begin
            chk("out_dr", out_dr_o[l*W +: W], exp_lane(out_n, l, 0));
            chk("out_di", out_di_o[l*W +: W], exp_lane(out_n, l, 1));
          end
          chk("out_last", out_last_o, out_n == 511);
        end else chk("extra_beat", 1, 0);
      end
      stall_prev = out_valid_o && !out_ready_i;
      held_dr = out_dr_o;
      held_di = out_di_o;
      if (out_valid_o && out_ready_i) begin
        popped++;
        out_n++;
        last_pop = out_last_o;
      end
      if (busy_o) chk("outstanding_le2", (issued - popped) <= 2, 1);
    end
  end

  task automatic gen(input int mode);
    for (int n = 0; n < 224; n++)
      for (int i = 0; i < 4; i++) begin
        if (mode == 0) begin
          gen_r[n][i] = W'(4 * n + i);
          gen_i[n][i] = W'(4 * n + i + 10000);
        end else if (mode == 1) begin
          gen_r[n][i] = W'($urandom);
          gen_i[n][i] = W'($urandom);
        end else begin
          gen_r[n][i] = gen_r[n][i] + W'(1000);
          gen_i[n][i] = gen_i[n][i] + W'(1000);
        end
      end
  endtask

  task automatic write_frame(input bit tog);
    int n, g;
    bit v, acc;
    n = 0; g = 0; v = 1;
    while (n < 224 && g < 3000) begin
      in_valid_i = v;
      for (int i = 0; i < 4; i++) begin
        in_dr_i[i*W +: W] = gen_r[n][i];
        in_di_i[i*W +: W] = gen_i[n][i];
      end
      @(negedge clk_i);
      acc = in_valid_i && in_ready_o;
      @(posedge clk_i);
      #1;
      if (acc) n++;
      if (tog) v = !v;
      g++;
    end
    in_valid_i = 0;
    chk("write_done", n, 224);
  endtask

  task automatic read_frame(input int mode);
    int g, f0;
    bit held;
    g = 0; f0 = frames_done; held = 0;
    while (frames_done == f0 && g < 6000) begin
      if (mode == 1 && !held && out_n >= 40) begin
        out_ready_i = 0;
        repeat (10) @(posedge clk_i);
        #1;
        held = 1;
      end
      out_ready_i = (mode == 2) ? ($urandom_range(0, 3) != 0) : 1'b1;
      @(posedge clk_i);
      #1;
      g++;
    end
    out_ready_i = 1;
    chk("read_done", frames_done - f0, 1);
  endtask

  task automatic reset_pulse();
    in_valid_i = 1'($urandom);
    in_dr_i = {2{32'($urandom)}};
    rst_i = 1;
    #1;
    chk("rst_outputs_zero", |{wr_en_l_o, addr_l_wr_o, dr_l_o, di_l_o, wr_en_s_o, addr_s_wr_o, dr_s_o, di_s_o,
                              rd_en_l_o, addr_l_rd_o, rd_en_s_o, addr_s_rd_o, out_dr_o, out_di_o}, 0);
    chk("rst_ctrl_zero", {in_ready_o, out_valid_o, out_last_o, busy_o}, 0);
    repeat (2) @(posedge clk_i);
    #1;
    rst_i = 0;
    in_valid_i = 0;
    @(negedge clk_i);
    chk("ready_after_rst", in_ready_o, 1);
    chk("idle_after_rst", busy_o, 0);
    @(posedge clk_i);
    #1;
  endtask

  initial begin
    #1;
    reset_pulse();
    gen(0);
    write_frame(0);
    chk("b0_wr_en_l", snap0_wl, 4'hF);
    chk("b0_addr", snap0_a, 0);
    chk("b130_wr_en_s", snap130_ws, 12'h00F);
    chk("b130_addr", snap130_a, 2);
    chk("model_pin_511_3", exp_lane(511, 3, 0), 895);
    chk("model_pin_129_2", exp_lane(129, 2, 0), 645);
    read_frame(0);
    chk("first_lane0", first_r[0], 0);
    chk("first_lane1", first_r[1], 512);
    chk("first_lane2", first_r[2], 640);
    chk("first_lane3", first_r[3], 768);
    chk("first_latency", first_delay, 2);
    chk("beats_per_frame", done_cnt, 512);
    gen(1);
    write_frame(1);
    read_frame(1);
    gen(2);
    write_frame(0);
    read_frame(2);
    chk("beats_frame3", done_cnt, 512);
    gen(1);
    write_frame(0);
    begin
      int g;
      g = 0;
      while (out_n < 300 && g < 3000) begin
        @(posedge clk_i);
        #1;
        g++;
      end
      chk("reach_rcnt300", out_n >= 300, 1);
    end
    #1;
    reset_pulse();
    gen(1);
    write_frame(0);
    read_frame(2);
    $display("test done: total=%0d bad=%0d", tot, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog got=timeout want=finish");
    $fatal(1, "watchdog");
  end
endmodule
